// File: rtl/pipe_pkg.sv
// Shared encodings and helpers for the pipe_reg handshake slice.
package pipe_pkg;

  // Occupancy encoding as {skid_valid, main_valid}.
  localparam logic [1:0] PR_EMPTY = 2'b00;
  localparam logic [1:0] PR_ONE   = 2'b01;
  localparam logic [1:0] PR_TWO   = 2'b11;

  localparam int PR_CNT_W = 2;

  function automatic logic [PR_CNT_W-1:0] pr_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register that only changes on an explicit load.
module pipe_slot #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= RESET_DATA;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Valid/ready pipeline slice with optional skid entry, flush and occupancy count.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter bit               SKID       = 1'b1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [PR_CNT_W-1:0] count
);

  logic                main_valid_q, main_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic [PR_CNT_W-1:0] count_q, count_d;
  logic                main_load, skid_load;
  logic [WIDTH-1:0]    main_d;
  logic [WIDTH-1:0]    skid_q;
  logic                accept, pop;

  assign accept = in_valid & in_ready;
  assign pop    = main_valid_q & out_ready;

  // With a skid entry in_ready comes straight from a flop; without one it must see out_ready.
  generate
    if (SKID) begin : g_rdy_reg
      assign in_ready = ~skid_valid_q;
    end else begin : g_rdy_comb
      assign in_ready = ~main_valid_q | out_ready;
    end
  endgenerate

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_load    = 1'b0;
    skid_load    = 1'b0;
    main_d       = in_data;
    case ({skid_valid_q, main_valid_q})
      PR_EMPTY: begin
        if (accept) begin
          main_load    = 1'b1;
          main_valid_d = 1'b1;
        end
      end
      PR_ONE: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept && SKID) begin
          skid_load    = 1'b1;
          skid_valid_d = 1'b1;
        end else if (pop) begin
          main_valid_d = 1'b0;
        end
      end
      PR_TWO: begin
        if (pop) begin
          main_load    = 1'b1;
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end
      end
      default: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
    // Flush drops everything; data registers keep their old contents.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_load    = 1'b0;
      skid_load    = 1'b0;
    end
    count_d = pr_count(main_valid_d, skid_valid_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      count_q      <= count_d;
    end
  end

  pipe_slot #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .d       (main_d),
    .q       (out_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (skid_load),
        .d       (in_data),
        .q       (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = RESET_DATA;
    end
  endgenerate

  assign out_valid = main_valid_q;
  assign count     = count_q;

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised pipeline register slice with valid/ready handshake on both sides. It is the successor to the plain enable register.
- Adds back-pressure, an optional skid entry for full throughput with a registered in_ready, synchronous flush, and an occupancy output.
- Sits between cpu32 pipeline stages (fetch->decode, decode->execute) and on bus request/response paths.

Parameters:
- WIDTH, 32, data path width in bits.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- RESET_DATA, 0, value loaded into all data registers on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active low; one clock; sampled on the rising edge of clk.
- flush  input  1  synchronous discard of all held entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  slice can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  payload; always driven from the main register.
- count  output  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Events: accept = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the same edge.
- Reset (reset_n=0 at edge):
  - main_valid=0, skid_valid=0.
  - main_data=skid_data=RESET_DATA.
  - out_valid=0, count=0.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides flush and any handshake. Entries in flight at reset are lost.
- Latency: an accepted word appears on out_data/out_valid the next cycle. Order is strictly FIFO. No combinational in->out data path.
- States when SKID=1 (encoded by main_valid and skid_valid):
  - EMPTY (0,0): in_ready=1. On accept: main<=in_data -> ONE.
  - ONE (1,0): in_ready=1.
    - accept & pop: main<=in_data, stay ONE.
    - accept & !pop: skid<=in_data -> TWO.
    - pop & !accept: -> EMPTY.
    - neither: hold.
  - TWO (1,1): in_ready=0, so accept is impossible.
    - pop: main<=skid_data, skid_valid<=0 -> ONE.
    - no pop: hold.
  - in_ready = !skid_valid, a registered value with no path from out_ready.
- SKID=0:
  - in_ready = !main_valid | out_ready (combinational).
  - accept loads main. pop without accept clears main_valid.
  - accept and pop in the same cycle: main<=in_data, and main_valid stays 1.
- Flush:
  - Both valids go to 0 at the edge. A simultaneous accept is discarded. A simultaneous pop still completes downstream.
  - Data registers are not cleared.
  - in_ready is 1 the cycle after the flush.
- Hold rule: out_data and out_valid are stable while out_valid=1 and out_ready=0. No glitch or change until pop.
- Data registers update only on load events, which limits switching.
- count = main_valid + skid_valid, registered.
- If in_valid=0, in_data is X-tolerant: an X on in_data must not propagate into state.

Decomposition:
- Package pipe_pkg:
  - State encoding constants PR_EMPTY=2'b00, PR_ONE=2'b01, PR_TWO=2'b11.
  - Localparam for count width.
- Sub-module pipe_slot (WIDTH, RESET_DATA):
  - Ports: clk, reset_n, load, d, q.
  - One data register with synchronous active-low reset.
  - Instantiated once for main, and again for skid under a generate on SKID=1.
- Handshake and state logic live in pipe_reg itself.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with in_valid=1 and in_data=32'hDEAD_BEEF -> out_valid=0, count=0, out_data=RESET_DATA. After release, in_ready=1.
2. Streaming, SKID=1: out_ready=1, in_valid=1, words 1,2,3,4 on consecutive cycles -> out_data is 1,2,3,4 starting 1 cycle later. in_ready stays 1 and there are no bubbles.
3. Back-pressure:
   - SKID=1: with out_ready=0, send 0xA then 0xB -> count=2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA then 0xB emerge, and in_ready returns to 1 the cycle after the first pop.
   - SKID=0: the same stimulus gives in_ready=0 after 0xA, and 0xB is accepted in the same cycle 0xA pops.
4. Flush: in TWO holding 0x11,0x22, assert flush together with in_valid=1 and in_data=0x33 -> next cycle out_valid=0, count=0. 0x33 never appears.
5. Reset mid-operation: in ONE with 0x55 and out_ready=0, pulse reset_n=0 -> out_valid=0 and count=0 the next cycle. 0x55 is never delivered.
6. Random stall: random in_valid/out_ready at 50% for 10k cycles -> the scoreboard shows in-order, lossless, duplicate-free transfer. With SKID=1, in_ready never depends combinationally on out_ready (formal/lint check).
